// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, func codes,
// ALU operations, FSM states and datapath select values.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_BAD = 3'b101;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_AND  = 2'd2,
    MODE_FUNC = 2'd3
  } alu_mode_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  function automatic logic func_supported(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: func_supported = 1'b1;
      default:                               func_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU mode (and the R-type func field) to an ALU operation code.
// The unsupported flag reflects func alone so the write-back state can use it.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUW = 3
) (
  input  alu_mode_t        alu_mode,
  input  logic [5:0]       func,
  output logic [ALUW-1:0]  alu_operation,
  output logic             unsupported
);

  logic [2:0] op_s;

  // Select operation from mode, falling through to func decode for R-type.
  always_comb begin
    op_s        = ALU_ADD;
    unsupported = ~func_supported(func);
    case (alu_mode)
      MODE_ADD: op_s = ALU_ADD;
      MODE_SUB: op_s = ALU_SUB;
      MODE_AND: op_s = ALU_AND;
      MODE_FUNC: begin
        case (func)
          FN_ADD:  op_s = ALU_ADD;
          FN_SUB:  op_s = ALU_SUB;
          FN_AND:  op_s = ALU_AND;
          FN_OR:   op_s = ALU_OR;
          FN_SLT:  op_s = ALU_SLT;
          default: op_s = ALU_BAD;
        endcase
      end
      default: op_s = ALU_ADD;
    endcase
  end

  assign alu_operation = ALUW'(op_s);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// with a mem_ready handshake and flags unsupported opcodes and R-type funcs.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit         MEM_HANDSHAKE = 1'b1,
  parameter logic [5:0] JR_OPCODE     = 6'b111111,
  parameter int         ALUW          = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            iord,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wd_sel,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic [ALUW-1:0] alu_operation,
  output logic            illegal,
  output logic [3:0]      state_dbg
);

  state_t    state_r;
  state_t    decode_next_s;
  logic      decode_ok_s;
  logic      rdy_s;
  alu_mode_t alu_mode_s;
  logic      unsupported_s;
  logic      pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s, illegal_s;

  assign rdy_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  alu_decoder #(.ALUW(ALUW)) u_alu_decoder (
    .alu_mode      (alu_mode_s),
    .func          (func),
    .alu_operation (alu_operation),
    .unsupported   (unsupported_s)
  );

  // Opcode dispatch out of DECODE; JR_OPCODE is a parameter so it sits in default.
  always_comb begin
    decode_next_s = S_FETCH;
    decode_ok_s   = 1'b1;
    case (opcode)
      OP_RTYPE:      decode_next_s = S_EXEC_R;
      OP_LW, OP_SW:  decode_next_s = S_MEM_ADDR;
      OP_BEQ, OP_BNE: decode_next_s = S_BRANCH;
      OP_ADDI, OP_ANDI: decode_next_s = S_EXEC_I;
      OP_J:          decode_next_s = S_JUMP;
      OP_JAL:        decode_next_s = S_JAL;
      default: begin
        if (opcode == JR_OPCODE) begin
          decode_next_s = S_JR;
        end else begin
          decode_next_s = S_FETCH;
          decode_ok_s   = 1'b0;
        end
      end
    endcase
  end

  // State register and next-state sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:    if (rdy_s) state_r <= S_DECODE;
        S_DECODE:   state_r <= decode_next_s;
        S_EXEC_R:   state_r <= S_R_WB;
        S_R_WB:     state_r <= S_FETCH;
        S_EXEC_I:   state_r <= S_I_WB;
        S_I_WB:     state_r <= S_FETCH;
        S_MEM_ADDR: state_r <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (rdy_s) state_r <= S_MEM_WB;
        S_MEM_WB:   state_r <= S_FETCH;
        S_MEM_WR:   if (rdy_s) state_r <= S_FETCH;
        S_BRANCH:   state_r <= S_FETCH;
        S_JUMP:     state_r <= S_FETCH;
        S_JAL:      state_r <= S_FETCH;
        S_JR:       state_r <= S_FETCH;
        default:    state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; strobes may follow mem_ready/zero in the same cycle.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    iord        = 1'b0;
    reg_dst     = DST_RT;
    wd_sel      = WD_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_src      = PCS_ALU;
    alu_mode_s  = MODE_ADD;
    case (state_r)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_s = rdy_s;
        pc_write_s = rdy_s;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        illegal_s = ~decode_ok_s;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_mode_s = MODE_FUNC;
      end
      S_R_WB: begin
        reg_dst     = DST_RD;
        reg_write_s = ~unsupported_s;
        illegal_s   = unsupported_s;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_ANDI) begin
          alu_mode_s = MODE_AND;
        end else begin
          alu_mode_s = MODE_ADD;
        end
      end
      S_I_WB:     reg_write_s = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        iord       = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        wd_sel      = WD_MDR;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        iord        = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_mode_s = MODE_SUB;
        pc_src     = PCS_ALUOUT;
        if (opcode == OP_BEQ) begin
          pc_write_s = zero;
        end else begin
          pc_write_s = ~zero;
        end
      end
      S_JUMP: begin
        pc_src     = PCS_JUMP;
        pc_write_s = 1'b1;
      end
      S_JAL: begin
        pc_src      = PCS_JUMP;
        pc_write_s  = 1'b1;
        reg_write_s = 1'b1;
        reg_dst     = DST_RA;
        wd_sel      = WD_PC;
      end
      S_JR: begin
        pc_src     = PCS_REG;
        pc_write_s = 1'b1;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Strobes are killed for as long as rst is high, not just from the next edge.
  assign pc_write  = pc_write_s  & ~rst;
  assign ir_write  = ir_write_s  & ~rst;
  assign mem_read  = mem_read_s  & ~rst;
  assign mem_write = mem_write_s & ~rst;
  assign reg_write = reg_write_s & ~rst;
  assign illegal   = illegal_s   & ~rst;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction effects (latency, strobe counts, selects)
// are predicted from the instruction-class rules and compared with the DUT.
module tb_multicycle_controller;

  logic       clk, rst;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_write, iord, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, wd_sel, alu_src_b, pc_src;
  logic       alu_src_a, illegal;
  logic [2:0] alu_operation;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_operation(alu_operation), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 5;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    case (o)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
      6'b001000, 6'b001100, 6'b000010, 6'b000011, 6'b111111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction starting in FETCH (called just after a rising edge).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fs, input int ms, input logic z);
    bit is_r, is_lw, is_sw, is_br, is_ill, taken, has_alu, mem;
    int exp_cyc, exp_rw, exp_dst, exp_wd, exp_src, exp_ill, exp_alu;
    int n_ir, n_pcw, n_rw, n_mw, n_mr, n_il, n_iord_bad, rdst, rwd, jsrc, alu_at;
    int c;
    bit seen, done;
    string t;

    is_r = (op == 6'b000000); is_lw = (op == 6'b100011); is_sw = (op == 6'b101011);
    is_br = (op == 6'b000100) || (op == 6'b000101);
    is_ill = !legal_op(op);
    mem = is_lw || is_sw;
    taken = 1'b0; exp_src = 0; exp_rw = 0; exp_dst = 0; exp_wd = 0; exp_ill = 0;
    has_alu = 1'b1; exp_alu = 2;
    if (is_ill) begin exp_cyc = 2 + fs; exp_ill = 1; has_alu = 1'b0; end
    else if (is_r) begin
      exp_cyc = 4 + fs; exp_alu = r_alu(fn);
      if (exp_alu == 5) exp_ill = 1; else begin exp_rw = 1; exp_dst = 1; end
    end
    else if (op == 6'b001000) begin exp_cyc = 4 + fs; exp_rw = 1; end
    else if (op == 6'b001100) begin exp_cyc = 4 + fs; exp_rw = 1; exp_alu = 0; end
    else if (is_sw) exp_cyc = 4 + fs + ms;
    else if (is_lw) begin exp_cyc = 5 + fs + ms; exp_rw = 1; exp_wd = 1; end
    else if (is_br) begin
      exp_cyc = 3 + fs; exp_alu = 6; exp_src = 1;
      taken = (op == 6'b000100) ? z : !z;
    end
    else begin
      exp_cyc = 3 + fs; has_alu = 1'b0; taken = 1'b1;
      if (op == 6'b000011) begin exp_src = 2; exp_rw = 1; exp_dst = 2; exp_wd = 2; end
      else if (op == 6'b000010) exp_src = 2;
      else exp_src = 3;
    end

    n_ir = 0; n_pcw = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_il = 0; n_iord_bad = 0;
    rdst = -1; rwd = -1; jsrc = -1; alu_at = -1;
    seen = 1'b0; done = 1'b0; c = 0;
    opcode = op; func = fn; zero = z;
    while (!done && c < 60) begin
      if (c < fs) mem_ready = 1'b0;
      else if (c == fs) mem_ready = 1'b1;
      else if (mem && c >= fs + 3 && c < fs + 3 + ms) mem_ready = 1'b0;
      else if (mem && c == fs + 3 + ms) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ir_write) n_ir++;
      if (pc_write) begin
        n_pcw++;
        if (!ir_write) jsrc = pc_src;
      end
      if (reg_write) begin n_rw++; rdst = reg_dst; rwd = wd_sel; end
      if (mem_write) n_mw++;
      if (mem_read) n_mr++;
      if (illegal) n_il++;
      if ((mem_read || mem_write) && (iord != (c > fs))) n_iord_bad++;
      if (c == fs + 2) alu_at = alu_operation;
      if (state_dbg != 4'd0) seen = 1'b1;
      @(posedge clk); #1;
      c++;
      if (seen && state_dbg == 4'd0) done = 1'b1;
    end

    t = $sformatf("op%b_fn%b_fs%0d_ms%0d_z%0d", op, fn, fs, ms, z);
    check({t, " done"}, int'(done), 1);
    check({t, " cycles"}, c, exp_cyc);
    check({t, " ir_write"}, n_ir, 1);
    check({t, " pc_write"}, n_pcw, 1 + int'(taken));
    if (taken) check({t, " pc_src"}, jsrc, exp_src);
    check({t, " reg_write"}, n_rw, exp_rw);
    if (exp_rw != 0) begin
      check({t, " reg_dst"}, rdst, exp_dst);
      check({t, " wd_sel"}, rwd, exp_wd);
    end
    check({t, " mem_write"}, n_mw, is_sw ? ms + 1 : 0);
    check({t, " mem_read"}, n_mr, fs + 1 + (is_lw ? ms + 1 : 0));
    check({t, " iord"}, n_iord_bad, 0);
    check({t, " illegal"}, n_il, exp_ill);
    if (has_alu) check({t, " alu_op"}, alu_at, exp_alu);
  endtask

  logic [5:0] legal_ops [10];
  logic [5:0] legal_fns [5];

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                  6'b001000, 6'b001100, 6'b000010, 6'b000011, 6'b111111};
    legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check("rst pc_write", pc_write, 0);
    check("rst ir_write", ir_write, 0);
    check("rst mem_read", mem_read, 0);
    check("rst reg_write", reg_write, 0);
    check("rst mem_write", mem_write, 0);
    check("rst state", state_dbg, 0);
    check("rst alu_src_b", alu_src_b, 1);
    check("rst alu_op", alu_operation, 2);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
    run_instr(6'b100011, 6'b000000, 2, 3, 1'b0);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b000011, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b111111, 6'b000000, 1, 0, 1'b0);
    run_instr(6'b010101, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b101011, 6'b000000, 0, 2, 1'b0);

    // sw held in MEM_WR, then reset asserted between edges.
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #2;
    check("sw stall mem_write", mem_write, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async rst mem_write", mem_write, 0);
    check("async rst state", state_dbg, 0);
    check("async rst reg_write", reg_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(6'b000000, 6'b100010, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      int k;
      k = $urandom_range(0, 11);
      if (k < 10) op = legal_ops[k];
      else begin
        op = 6'($urandom);
        while (legal_op(op)) op = 6'($urandom);
      end
      if ($urandom_range(0, 3) != 0) fn = legal_fns[$urandom_range(0, 4)];
      else fn = 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
